accumulator_core: RTL and testbench

Parametrised successor of the team's 8-bit accumulator processor top level. It merges the register file, ALU, accumulator mux, program counter, instruction register and controller FSM into one core with configurable data, operand and PC widths. It adds a stall-capable instruction-fetch handshake, registered Z/C flags, conditional branches and a halt state. It sits between the instruction memory and the rest of the SoC.

---
 rtl/accumulator_core.sv | 166 ++++++++++++++++
 tb/tb_accumulator_core.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/accumulator_core.sv
// Accumulator core: two-cycle fetch/execute processor with a register file, Z/C flags, branches and halt.
// Latency: 2 cycles per instruction (FETCH + EXEC) with zero-wait memory, +1 per cycle imem_ack stays low.
// Backpressure: FETCH holds imem_req/imem_addr stable until imem_ack; imem_ack is ignored outside FETCH.
//
// Ports:
//   CLK, CLB        clock; synchronous active-high reset
//   imem_req/addr   fetch request and address (= PC), request high only in FETCH
//   imem_ack/data   instruction handshake; data = {opcode[3:0], operand[OPER_W-1:0]}
//   acc_out, z_out, c_out, halted   architectural state
// Optional build macro ACC_SAT_EN: ADD saturates to all-ones on carry, SUB saturates to 0 on borrow.
module accumulator_core #(
  parameter int DATA_W = 8,
  parameter int OPER_W = 4,
  parameter int PC_W   = 8
) (
  input  logic              CLK,
  input  logic              CLB,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [OPER_W+3:0] imem_data,
  output logic [DATA_W-1:0] acc_out,
  output logic              z_out,
  output logic              c_out,
  output logic              halted
);

  localparam int NUM_REGS = 2 ** OPER_W;

  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_LDR = 4'h2;
  localparam logic [3:0] OP_STR = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8;
  localparam logic [3:0] OP_NOT = 4'h9;
  localparam logic [3:0] OP_SHL = 4'hA;
  localparam logic [3:0] OP_SHR = 4'hB;
  localparam logic [3:0] OP_JMP = 4'hC;
  localparam logic [3:0] OP_JZ  = 4'hD;
  localparam logic [3:0] OP_JC  = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {FETCH, EXEC, HALT} stateT;

  stateT             state;
  logic [DATA_W-1:0] acc;
  logic [PC_W-1:0]   pc;
  logic [OPER_W+3:0] ir;
  logic              zFlag;
  logic              cFlag;
  logic [DATA_W-1:0] regFile [NUM_REGS];

  logic [3:0]        opcode;
  logic [OPER_W-1:0] operand;
  logic [DATA_W-1:0] rVal;
  logic [DATA_W-1:0] imm;
  logic [PC_W-1:0]   jumpTgt;
  logic [DATA_W:0]   sumW;
  logic [DATA_W:0]   diffW;
  logic [DATA_W-1:0] nextAcc;
  logic              nextC;
  logic              accWr;
  logic              branchTaken;

  assign opcode  = ir[OPER_W+3:OPER_W];
  assign operand = ir[OPER_W-1:0];
  assign rVal    = regFile[operand];
  assign imm     = DATA_W'(operand);
  // Register value zero-extended or truncated to the PC width.
  assign jumpTgt = PC_W'(rVal);

  // One extra bit holds carry-out for ADD and borrow for SUB.
  assign sumW  = {1'b0, acc} + {1'b0, rVal};
  assign diffW = {1'b0, acc} - {1'b0, rVal};

  always_comb begin
    nextAcc = acc;
    nextC   = cFlag;
    accWr   = 1'b0;
    case (opcode)
      OP_LDI: begin nextAcc = imm;  accWr = 1'b1; end
      OP_LDR: begin nextAcc = rVal; accWr = 1'b1; end
      OP_ADD: begin
        nextC   = sumW[DATA_W];
        nextAcc = sumW[DATA_W-1:0];
`ifdef ACC_SAT_EN
        if (sumW[DATA_W]) nextAcc = '1;
`endif
        accWr = 1'b1;
      end
      OP_SUB: begin
        nextC   = diffW[DATA_W];
        nextAcc = diffW[DATA_W-1:0];
`ifdef ACC_SAT_EN
        if (diffW[DATA_W]) nextAcc = '0;
`endif
        accWr = 1'b1;
      end
      OP_AND: begin nextAcc = acc & rVal; accWr = 1'b1; end
      OP_OR:  begin nextAcc = acc | rVal; accWr = 1'b1; end
      OP_XOR: begin nextAcc = acc ^ rVal; accWr = 1'b1; end
      OP_NOT: begin nextAcc = ~acc;       accWr = 1'b1; end
      OP_SHL: begin
        nextC   = acc[DATA_W-1];
        nextAcc = {acc[DATA_W-2:0], 1'b0};
        accWr   = 1'b1;
      end
      OP_SHR: begin
        nextC   = acc[0];
        nextAcc = {1'b0, acc[DATA_W-1:1]};
        accWr   = 1'b1;
      end
      default: ;
    endcase
  end

  // Conditional branches test the flags left by earlier instructions.
  assign branchTaken = (opcode == OP_JMP) ||
                       ((opcode == OP_JZ) && zFlag) ||
                       ((opcode == OP_JC) && cFlag);

  always_ff @(posedge CLK) begin
    if (CLB) begin
      state <= FETCH;
      acc   <= '0;
      pc    <= '0;
      ir    <= '0;
      zFlag <= 1'b0;
      cFlag <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regFile[i] <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack) begin
            ir    <= imem_data;
            pc    <= pc + PC_W'(1);
            state <= EXEC;
          end
        end
        EXEC: begin
          if (accWr) begin
            acc   <= nextAcc;
            zFlag <= (nextAcc == '0);
          end
          cFlag <= nextC;
          if (opcode == OP_STR) regFile[operand] <= acc;
          if (branchTaken) pc <= jumpTgt;
          state <= (opcode == OP_HLT) ? HALT : FETCH;
        end
        HALT:    state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;
  assign halted    = (state == HALT);
  assign acc_out   = acc;
  assign z_out     = zFlag;
  assign c_out     = cFlag;

endmodule

// File: tb/tb_accumulator_core.sv
// Bench for accumulator_core: directed scenarios plus random programs against an instruction-level model.
// Latency: checks land on the falling edge after each FETCH/EXEC pair.
// Backpressure: stalls are produced by holding imem_ack low for a chosen number of cycles.
module tb_accumulator_core;

  logic       CLK = 1'b0;
  logic       CLB;
  logic       imem_ack;
  logic [7:0] imem_data;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic [7:0] acc_out;
  logic       z_out;
  logic       c_out;
  logic       halted;

  // Second core with a wider datapath to exercise jump-target truncation.
  logic        rst2;
  logic        req2;
  logic [7:0]  addr2;
  logic [7:0]  data2;
  logic [11:0] acc2;
  logic        z2;
  logic        c2;
  logic        halt2;
  logic [7:0]  rom2 [256];
  bit          seenFF = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Instruction-level reference state.
  int mAcc, mPc, mZ, mC, mHalt;
  int mReg [16];

  accumulator_core #(.DATA_W(8), .OPER_W(4), .PC_W(8)) dut (
    .CLK(CLK), .CLB(CLB),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .acc_out(acc_out), .z_out(z_out), .c_out(c_out), .halted(halted)
  );

  accumulator_core #(.DATA_W(12), .OPER_W(4), .PC_W(8)) dut2 (
    .CLK(CLK), .CLB(rst2),
    .imem_req(req2), .imem_addr(addr2),
    .imem_ack(1'b1), .imem_data(data2),
    .acc_out(acc2), .z_out(z2), .c_out(c2), .halted(halt2)
  );

  assign data2 = rom2[addr2];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK) if (req2 === 1'b1 && addr2 === 8'hFF) seenFF <= 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mReset();
    mAcc = 0; mPc = 0; mZ = 0; mC = 0; mHalt = 0;
    for (int i = 0; i < 16; i++) mReg[i] = 0;
  endtask

  task automatic mExec(input logic [7:0] instr);
    int op, opd, r, s;
    bit wz;
    op  = int'(instr[7:4]);
    opd = int'(instr[3:0]);
    r   = mReg[opd];
    wz  = 1'b0;
    case (op)
      1:  begin mAcc = opd; wz = 1'b1; end
      2:  begin mAcc = r;   wz = 1'b1; end
      3:  mReg[opd] = mAcc;
      4:  begin
        s  = mAcc + r;
        mC = (s > 255) ? 1 : 0;
`ifdef ACC_SAT_EN
        mAcc = mC ? 255 : s;
`else
        mAcc = s % 256;
`endif
        wz = 1'b1;
      end
      5:  begin
        mC = (mAcc < r) ? 1 : 0;
`ifdef ACC_SAT_EN
        mAcc = mC ? 0 : mAcc - r;
`else
        mAcc = (mAcc - r + 256) % 256;
`endif
        wz = 1'b1;
      end
      6:  begin mAcc = mAcc & r; wz = 1'b1; end
      7:  begin mAcc = mAcc | r; wz = 1'b1; end
      8:  begin mAcc = mAcc ^ r; wz = 1'b1; end
      9:  begin mAcc = 255 - mAcc; wz = 1'b1; end
      10: begin mC = (mAcc >= 128) ? 1 : 0; mAcc = (mAcc * 2) % 256; wz = 1'b1; end
      11: begin mC = mAcc % 2; mAcc = mAcc / 2; wz = 1'b1; end
      12: mPc = r % 256;
      13: if (mZ != 0) mPc = r % 256;
      14: if (mC != 0) mPc = r % 256;
      15: mHalt = 1;
      default: ;
    endcase
    if (wz) mZ = (mAcc == 0) ? 1 : 0;
  endtask

  // Reset for n cycles, optionally with a competing ack, then check the reset state.
  task automatic doReset(input int n, input bit ackDuring);
    CLB       = 1'b1;
    imem_ack  = ackDuring;
    imem_data = 8'h17;
    repeat (n) @(negedge CLK);
    CLB      = 1'b0;
    imem_ack = 1'b0;
    mReset();
    check("rstAcc",  acc_out,   0);
    check("rstAddr", imem_addr, 0);
    check("rstReq",  imem_req,  1);
    check("rstZ",    z_out,     0);
    check("rstC",    c_out,     0);
    check("rstHalt", halted,    0);
  endtask

  // Serve one instruction at the current fetch, with optional stall cycles and a stray ack during EXEC.
  task automatic execInstr(input logic [7:0] instr, input int stalls, input bit ackInExec);
    check("fetchReq",  imem_req,  1);
    check("fetchAddr", imem_addr, mPc);
    for (int i = 0; i < stalls; i++) begin
      imem_ack  = 1'b0;
      imem_data = 8'($urandom);
      @(negedge CLK);
      check("stallReq",  imem_req,  1);
      check("stallAddr", imem_addr, mPc);
      check("stallAcc",  acc_out,   mAcc);
    end
    imem_ack  = 1'b1;
    imem_data = instr;
    @(negedge CLK);
    mPc = (mPc + 1) % 256;
    check("execReq", imem_req, 0);
    imem_ack  = ackInExec;
    imem_data = 8'($urandom);
    @(negedge CLK);
    imem_ack = 1'b0;
    mExec(instr);
    check("acc",  acc_out, mAcc);
    check("z",    z_out,   mZ);
    check("c",    c_out,   mC);
    check("halt", halted,  mHalt);
    if (mHalt != 0) check("haltReq", imem_req, 0);
    else            check("nextAddr", imem_addr, mPc);
  endtask

  initial begin
    int t0;
    logic [7:0] progA [5];
    logic [7:0] progFF [10];

    CLB = 1'b1; rst2 = 1'b1; imem_ack = 1'b0; imem_data = 8'h00;
    for (int i = 0; i < 256; i++) rom2[i] = 8'h00;
    rom2[0] = 8'h11; rom2[1] = 8'h32; rom2[2] = 8'h1F; rom2[3] = 8'h31;
    for (int i = 4; i < 8; i++) rom2[i] = 8'hA0;
    rom2[8] = 8'h71; rom2[9] = 8'hA0; rom2[10] = 8'h72; rom2[11] = 8'h34;
    rom2[12] = 8'hC4; rom2[13] = 8'h10; rom2[14] = 8'hF0; rom2[255] = 8'hF0;

    // Reset held two cycles with an ack present.
    doReset(2, 1'b1);
    rst2 = 1'b0;

    // LDI 5; STR 3; LDI F; ADD 3; HLT
    progA = '{8'h15, 8'h33, 8'h1F, 8'h43, 8'hF0};
    t0 = cyc;
    for (int i = 0; i < 5; i++) execInstr(progA[i], 0, 1'b0);
    check("progA_cycles", cyc - t0, 10);
    check("progA_acc",    acc_out,  8'h14);
    check("progA_addr",   imem_addr, 8'h05);
    check("progA_req",    imem_req, 0);
    check("progA_halt",   halted,   1);

    // Halted core sees more ack traffic, then reset with an ack in the reset cycle.
    imem_ack = 1'b1;
    repeat (2) @(negedge CLK);
    check("haltHold", halted, 1);
    doReset(1, 1'b1);
    execInstr(8'h23, 0, 1'b0);  // LDR 3: register file must be cleared

    // Build 0xFF then add 1.
    progFF = '{8'h1F, 8'h31, 8'hA0, 8'hA0, 8'hA0, 8'hA0, 8'h71, 8'h32, 8'h11, 8'h42};
    for (int i = 0; i < 10; i++) execInstr(progFF[i], 0, 1'b0);
`ifdef ACC_SAT_EN
    check("ffAcc", acc_out, 8'hFF);
    check("ffC",   c_out,   1);
    check("ffZ",   z_out,   0);
`else
    check("ffAcc", acc_out, 8'h00);
    check("ffC",   c_out,   1);
    check("ffZ",   z_out,   1);
`endif

    // Branches: REG4 = 0x20.
    doReset(1, 1'b0);
    execInstr(8'h12, 0, 1'b0);
    for (int i = 0; i < 4; i++) execInstr(8'hA0, 0, 1'b0);
    execInstr(8'h34, 0, 1'b0);
    execInstr(8'h10, 0, 1'b0);
    execInstr(8'hD4, 0, 1'b1);
    check("jzTaken", imem_addr, 8'h20);
    execInstr(8'h11, 0, 1'b0);
    execInstr(8'hD4, 0, 1'b0);
    check("jzNotTaken", imem_addr, 8'h22);

    // Reset in the middle of a stall with an ack in the reset cycle.
    imem_ack = 1'b0;
    @(negedge CLK);
    check("preRstReq", imem_req, 1);
    doReset(1, 1'b1);
    execInstr(8'h24, 0, 1'b0);  // LDR 4 reads cleared register
    execInstr(8'h19, 0, 1'b0);

    // Three stall cycles at PC=0x02.
    check("stallPc", imem_addr, 8'h02);
    t0 = cyc;
    execInstr(8'h13, 3, 1'b0);
    check("stallCycles", cyc - t0, 5);

    // Random programs against the model.
    doReset(1, 1'b0);
    for (int n = 0; n < 400; n++) begin
      execInstr(8'($urandom_range(0, 255)), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      if (mHalt != 0) doReset(1, 1'($urandom_range(0, 1)));
    end

    // Wide-datapath core: REG4 = 0x1FF, JMP 4 lands on 0xFF, HLT there wraps PC to 0.
    check("truncAcc",  acc2,   12'h1FF);
    check("truncSeen", seenFF, 1);
    check("truncHalt", halt2,  1);
    check("truncWrap", addr2,  8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
